adder_operand_sequencer: RTL and testbench

Self-test stimulus and checker stage that sits directly upstream of tt_um_parallel_adder.
- Drives A/B/Cin through every operand combination, holding each vector for MAX_COUNT clocks.
- Samples the adder's Sum/Cout back and compares them against an internal golden sum.
- Reports error count, first failing vector and pass/done status for on-chip bring-up.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_operand_sequencer_hold_counter.sv | 30 +++
 rtl/adder_operand_sequencer.sv | 140 ++++++++++++++
 tb/tb_adder_operand_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and golden model for the parallel-adder self-test sequencer.
package adder_pkg;

  localparam int WIDTH_DEF = 3;
  localparam int VEC_W     = 2*WIDTH_DEF+1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operands arrive zero-extended to 32 bits so one function serves any WIDTH < 32.
  function automatic logic [32:0] golden_sum(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        cin);
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

endpackage

// File: rtl/adder_operand_sequencer_hold_counter.sv
// Per-vector hold prescaler: counts 0..MAX_COUNT-1 while enabled and flags the last cycle.
module hold_counter #(
  parameter int MAX_COUNT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_last
);

  localparam int CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT-1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  // The pulse is qualified by enable so a paused last cycle never samples.
  assign w_last = i_en && (r_cnt == LAST);
  assign o_last = w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adder_operand_sequencer.sv
// Sweeps {A,B,Cin} over every combination, holds each for MAX_COUNT clocks and
// checks the adder's registered {Cout,Sum} against the golden sum.
module adder_operand_sequencer
  import adder_pkg::*;
#(
  parameter int MAX_COUNT = 1000,
  parameter int WIDTH     = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic               Cin,
  input  logic [WIDTH-1:0]   Sum,
  input  logic               Cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_count,
  output logic [2*WIDTH:0]   first_err_vec
);

  localparam int VW = 2*WIDTH+1;

  state_t          r_state, w_state_nxt;
  logic [VW-1:0]   r_vec, w_vec_nxt;
  logic [VW-1:0]   r_ops, w_ops_nxt;
  logic [7:0]      r_err, w_err_nxt;
  logic [VW-1:0]   r_first, w_first_nxt;
  logic            r_has_err, w_has_err_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_pass, w_pass_nxt;

  logic            w_start_acc;
  logic            w_cnt_en;
  logic            w_last;
  logic            w_sweep_end;
  logic            w_match;
  logic [32:0]     w_gold;
  logic [32:0]     w_obs;

  assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_cnt_en    = (r_state == RUN) && !pause;
  assign w_sweep_end = w_last && (r_vec == '1);

  hold_counter #(
    .MAX_COUNT (MAX_COUNT)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_cnt_en),
    .i_clr  (w_start_acc),
    .o_last (w_last)
  );

  // Compare against the operands actually presented to the adder.
  assign w_gold  = golden_sum(32'(r_ops[WIDTH+1 +: WIDTH]), 32'(r_ops[1 +: WIDTH]), r_ops[0]);
  assign w_obs   = 33'({Cout, Sum});
  assign w_match = (w_gold == w_obs);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_sweep_end) w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_vec_nxt     = r_vec;
    w_err_nxt     = r_err;
    w_first_nxt   = r_first;
    w_has_err_nxt = r_has_err;
    if (w_start_acc) begin
      w_vec_nxt     = '0;
      w_err_nxt     = '0;
      w_first_nxt   = '0;
      w_has_err_nxt = 1'b0;
    end else if (w_last) begin
      // The final vector is not wrapped; the index rests at all-ones in DONE.
      if (!w_sweep_end) w_vec_nxt = r_vec + 1'b1;
      if (!w_match) begin
        if (r_err != 8'hFF) w_err_nxt = r_err + 8'd1;
        if (!r_has_err) begin
          w_first_nxt   = r_vec;
          w_has_err_nxt = 1'b1;
        end
      end
    end
    w_ops_nxt  = (w_state_nxt == RUN) ? w_vec_nxt : '0;
    w_busy_nxt = (r_state == RUN);
    w_done_nxt = (r_state == DONE) && !start;
    w_pass_nxt = w_done_nxt && (r_err == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec     <= '0;
      r_ops     <= '0;
      r_err     <= '0;
      r_first   <= '0;
      r_has_err <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_vec     <= w_vec_nxt;
      r_ops     <= w_ops_nxt;
      r_err     <= w_err_nxt;
      r_first   <= w_first_nxt;
      r_has_err <= w_has_err_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
    end
  end

  assign A             = r_ops[WIDTH+1 +: WIDTH];
  assign B             = r_ops[1 +: WIDTH];
  assign Cin           = r_ops[0];
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err;
  assign first_err_vec = r_first;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer driving a registered 3-bit adder model with optional stuck faults.
module tb_adder_operand_sequencer;

  localparam int MC = 4;
  localparam int W  = 3;

  logic         clk = 1'b0;
  logic         rst, start, pause;
  logic [W-1:0] A, B, Sum;
  logic         Cin, Cout;
  logic         busy, done, pass;
  logic [7:0]   err_count;
  logic [2*W:0] first_err_vec;

  int           fault;
  logic [W:0]   r_add;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int fault;
    int pause_at;
    int pause_len;
    int restart_at;
    int exp_lat;
    int exp_busy;
    int exp_err;
    int exp_first;
    int exp_pass;
  } sweep_t;

  sweep_t tbl[5];
  sweep_t sb[$];

  always #5 clk = ~clk;

  adder_operand_sequencer #(.MAX_COUNT(MC), .WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pause         (pause),
    .A             (A),
    .B             (B),
    .Cin           (Cin),
    .Sum           (Sum),
    .Cout          (Cout),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_vec (first_err_vec)
  );

  // Registered adder with selectable stuck-at-0 faults on Sum[0] or Cout.
  always @(posedge clk) r_add <= {1'b0, A} + {1'b0, B} + {3'b000, Cin};
  assign Sum  = (fault == 1) ? (r_add[W-1:0] & 3'b110) : r_add[W-1:0];
  assign Cout = (fault == 2) ? 1'b0 : r_add[W];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_pass"}, int'(pass), 0);
    chk({name, "_err"},  int'(err_count), 0);
    chk({name, "_first"}, int'(first_err_vec), 0);
    chk({name, "_ops"},  int'({A, B, Cin}), 0);
  endtask

  task automatic run_sweep(input sweep_t rec);
    int          cycles;
    int          busy_cnt;
    bit          got_done;
    bit          stable;
    logic [2*W:0] held;
    sweep_t      exp;
    fault = rec.fault;
    sb.push_back(rec);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    got_done = 1'b0;
    stable   = 1'b1;
    held     = '0;
    while (!got_done && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) chk("done_clear", int'(done), 0);
      if (busy) busy_cnt++;
      if (done) got_done = 1'b1;
      if (cycles > rec.pause_at && cycles <= rec.pause_at + rec.pause_len && {A, B, Cin} != held)
        stable = 1'b0;
      if (cycles == rec.pause_at) held = {A, B, Cin};
      pause = (rec.pause_len > 0) && (cycles >= rec.pause_at) && (cycles < rec.pause_at + rec.pause_len);
      start = (rec.restart_at != 0) && (cycles == rec.restart_at);
    end
    pause = 1'b0;
    start = 1'b0;
    exp = sb.pop_front();
    chk("done_seen", int'(got_done), 1);
    chk("latency", cycles, exp.exp_lat);
    chk("busy_cycles", busy_cnt, exp.exp_busy);
    chk("err_count", int'(err_count), exp.exp_err);
    chk("first_err_vec", int'(first_err_vec), exp.exp_first);
    chk("pass", int'(pass), exp.exp_pass);
    chk("ops_idle", int'({A, B, Cin}), 0);
    if (rec.pause_len > 0) chk("pause_stable", int'(stable), 1);
  endtask

  initial begin
    int  n;
    bit  hit;
    tbl[0] = '{fault:0, pause_at:0,   pause_len:0,  restart_at:0,   exp_lat:513, exp_busy:512, exp_err:0,  exp_first:0,     exp_pass:1};
    tbl[1] = '{fault:1, pause_at:0,   pause_len:0,  restart_at:0,   exp_lat:513, exp_busy:512, exp_err:64, exp_first:'h01, exp_pass:0};
    tbl[2] = '{fault:2, pause_at:0,   pause_len:0,  restart_at:0,   exp_lat:513, exp_busy:512, exp_err:64, exp_first:'h0F, exp_pass:0};
    tbl[3] = '{fault:0, pause_at:100, pause_len:10, restart_at:0,   exp_lat:523, exp_busy:522, exp_err:0,  exp_first:0,     exp_pass:1};
    tbl[4] = '{fault:0, pause_at:0,   pause_len:0,  restart_at:200, exp_lat:513, exp_busy:512, exp_err:0,  exp_first:0,     exp_pass:1};

    rst   = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    fault = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    pause = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_pause_busy", int'(busy), 0);
    pause = 1'b0;

    for (int i = 0; i < 5; i++) run_sweep(tbl[i]);

    // Abort mid-sweep once the operands reach vector 50.
    fault = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if ({A, B, Cin} == 7'd50) hit = 1'b1;
    end
    chk("vec50_reached", int'(hit), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("mid_rst");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_idle", int'(busy), 0);

    // rst and start together: reset wins, nothing starts.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_busy", int'(busy), 0);
    chk("rst_start_ops", int'({A, B, Cin}), 0);

    run_sweep(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
